// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline definitions: payload width, bubble encoding, buffer modes,
// and a small helper for counting valid entries.
package pipe_stage_reg_pkg;

    // IF/ID payload is PC concatenated with the instruction word.
    localparam int PIPE_IFID_WIDTH = 64;

    // A bubble is an all-zero payload; replicate this bit to any width.
    localparam logic PIPE_BUBBLE_BIT = 1'b0;

    // Buffering mode selected by the SKID parameter of the stage register.
    typedef enum logic {
        PIPE_SINGLE = 1'b0,
        PIPE_SKID   = 1'b1
    } pipe_mode_e;

    // Number of valid entries among main and skid (0..2).
    function automatic logic [1:0] valid_count(input logic main_v, input logic skid_v);
        return {1'b0, main_v} + {1'b0, skid_v};
    endfunction

endpackage

// File: rtl/pipe_entry.sv
// One pipeline slot: a valid bit plus payload with hold, clear and load
// controls. Hold beats clear, clear beats load; a cleared slot stores a bubble.
module pipe_entry
    import pipe_stage_reg_pkg::*;
#(
    parameter int WIDTH = PIPE_IFID_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_hold,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    // Slot state: reset to bubble, freeze on hold, otherwise clear or load.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_data  <= {WIDTH{PIPE_BUBBLE_BIT}};
        end else if (!i_hold) begin
            if (i_clear) begin
                r_valid <= 1'b0;
                r_data  <= {WIDTH{PIPE_BUBBLE_BIT}};
            end else if (i_load) begin
                r_valid <= 1'b1;
                r_data  <= i_data;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, hazard hold,
// flush-to-bubble and an optional second (skid) entry. Also counts how many
// valid entries flushes have thrown away, saturating at all-ones.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int WIDTH = PIPE_IFID_WIDTH,
    parameter int SKID  = 0,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam pipe_mode_e MODE = (SKID != 0) ? PIPE_SKID : PIPE_SINGLE;

    logic             w_enq;
    logic             w_deq;
    logic             w_main_v;
    logic [WIDTH-1:0] w_main_data;
    logic             w_main_load;
    logic             w_main_clear;
    logic [WIDTH-1:0] w_main_din;
    logic             w_skid_v;

    logic [CNT_W:0]   w_cnt_sum;
    logic [CNT_W-1:0] w_drop_cnt_next;
    logic [CNT_W-1:0] r_drop_cnt;

    // Transfers; hold is folded into in_ready on the enqueue side.
    assign w_enq = in_valid && in_ready;
    assign w_deq = w_main_v && out_ready && !hold;

    pipe_entry #(.WIDTH(WIDTH)) u_main (
        .clk     (clk),
        .rst     (rst),
        .i_hold  (hold),
        .i_clear (w_main_clear),
        .i_load  (w_main_load),
        .i_data  (w_main_din),
        .o_valid (w_main_v),
        .o_data  (w_main_data)
    );

    generate
        if (MODE == PIPE_SKID) begin : g_skid
            logic [WIDTH-1:0] w_skid_data;
            logic             w_skid_load;
            logic             w_skid_clear;

            // Registered-only ready: depends on skid occupancy, not out_ready.
            assign in_ready = !w_skid_v && !hold && !flush;

            // Head refills from skid first (FIFO order), else from upstream
            // when the head is empty or leaving this cycle.
            assign w_main_load  = (w_enq && (!w_main_v || w_deq)) || (w_deq && w_skid_v);
            assign w_main_din   = w_skid_v ? w_skid_data : in_data;
            assign w_main_clear = flush || (w_deq && !w_skid_v && !w_enq);

            // Skid catches the beat that arrives while the head is stuck.
            assign w_skid_load  = w_enq && w_main_v && !w_deq;
            assign w_skid_clear = flush || (w_deq && w_skid_v);

            pipe_entry #(.WIDTH(WIDTH)) u_skid (
                .clk     (clk),
                .rst     (rst),
                .i_hold  (hold),
                .i_clear (w_skid_clear),
                .i_load  (w_skid_load),
                .i_data  (in_data),
                .o_valid (w_skid_v),
                .o_data  (w_skid_data)
            );
        end else begin : g_single
            // Single slot: accept when empty or when the head leaves now.
            assign in_ready     = !hold && !flush && (!w_main_v || out_ready);
            assign w_main_load  = w_enq;
            assign w_main_din   = in_data;
            assign w_main_clear = flush || (w_deq && !w_enq);
            assign w_skid_v     = 1'b0;
        end
    endgenerate

    // Flushed-entry count with saturation at all-ones.
    assign w_cnt_sum       = {1'b0, r_drop_cnt} + (CNT_W + 1)'(valid_count(w_main_v, w_skid_v));
    assign w_drop_cnt_next = w_cnt_sum[CNT_W] ? {CNT_W{1'b1}} : w_cnt_sum[CNT_W-1:0];

    // Drop counter: cleared by reset, frozen by hold, bumped by a live flush.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_drop_cnt <= '0;
        end else if (!hold && flush) begin
            r_drop_cnt <= w_drop_cnt_next;
        end
    end

    assign out_valid = w_main_v;
    assign out_data  = w_main_v ? w_main_data : {WIDTH{PIPE_BUBBLE_BIT}};
    assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: three instances share one stimulus
// (skid mode, single mode, skid mode with a 2-bit drop counter).
module tb_pipe_stage_reg;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         hold;
    logic         flush;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         out_ready;

    logic         s_in_ready, s_out_valid;
    logic [W-1:0] s_out_data;
    logic [15:0]  s_drop_cnt;
    logic         n_in_ready, n_out_valid;
    logic [W-1:0] n_out_data;
    logic [15:0]  n_drop_cnt;
    logic         t_in_ready, t_out_valid;
    logic [W-1:0] t_out_data;
    logic [1:0]   t_drop_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.WIDTH(W), .SKID(1), .CNT_W(16)) dut_skid (
        .clk(clk), .rst(rst), .hold(hold), .flush(flush),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
        .drop_cnt(s_drop_cnt)
    );

    pipe_stage_reg #(.WIDTH(W), .SKID(0), .CNT_W(16)) dut_single (
        .clk(clk), .rst(rst), .hold(hold), .flush(flush),
        .in_valid(in_valid), .in_ready(n_in_ready), .in_data(in_data),
        .out_valid(n_out_valid), .out_ready(out_ready), .out_data(n_out_data),
        .drop_cnt(n_drop_cnt)
    );

    pipe_stage_reg #(.WIDTH(W), .SKID(1), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .hold(hold), .flush(flush),
        .in_valid(in_valid), .in_ready(t_in_ready), .in_data(in_data),
        .out_valid(t_out_valid), .out_ready(out_ready), .out_data(t_out_data),
        .drop_cnt(t_drop_cnt)
    );

    // Apply inputs on the falling edge, then let combinational outputs settle.
    task automatic drive(input logic v, input logic [W-1:0] d, input logic ordy,
                         input logic h, input logic f);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        hold      = h;
        flush     = f;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        checks++; if (s_out_valid !== 1'b0) begin failures++; $display("FAIL reset_s_valid: got %b want 0", s_out_valid); end
        checks++; if (s_out_data !== 16'h0) begin failures++; $display("FAIL reset_s_data: got %h want 0000", s_out_data); end
        checks++; if (s_drop_cnt !== 16'd0) begin failures++; $display("FAIL reset_s_drop: got %0d want 0", s_drop_cnt); end
        checks++; if (n_out_valid !== 1'b0) begin failures++; $display("FAIL reset_n_valid: got %b want 0", n_out_valid); end
        checks++; if (n_drop_cnt !== 16'd0) begin failures++; $display("FAIL reset_n_drop: got %0d want 0", n_drop_cnt); end
        checks++; if (t_drop_cnt !== 2'd0) begin failures++; $display("FAIL reset_t_drop: got %0d want 0", t_drop_cnt); end
        $display("reset: s_valid=%b s_drop=%0d n_valid=%b t_drop=%0d", s_out_valid, s_drop_cnt, n_out_valid, t_drop_cnt);
        rst = 1'b1;
    endtask

    task automatic test_stream();
        logic         v_tab [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [W-1:0] d_tab [5] = '{16'h11, 16'h22, 16'h33, 16'h0, 16'h0};
        logic         ev_tab[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [W-1:0] ed_tab[5] = '{16'h0, 16'h11, 16'h22, 16'h33, 16'h0};
        test_reset();
        for (int i = 0; i < 5; i++) begin
            drive(v_tab[i], d_tab[i], 1'b1, 1'b0, 1'b0);
            $display("stream[%0d]: s_valid=%b s_data=%h n_valid=%b n_data=%h", i, s_out_valid, s_out_data, n_out_valid, n_out_data);
            checks++; if (s_in_ready !== 1'b1) begin failures++; $display("FAIL stream_s_ready[%0d]: got %b want 1", i, s_in_ready); end
            checks++; if (s_out_valid !== ev_tab[i]) begin failures++; $display("FAIL stream_s_valid[%0d]: got %b want %b", i, s_out_valid, ev_tab[i]); end
            checks++; if (s_out_data !== ed_tab[i]) begin failures++; $display("FAIL stream_s_data[%0d]: got %h want %h", i, s_out_data, ed_tab[i]); end
            checks++; if (n_out_valid !== ev_tab[i]) begin failures++; $display("FAIL stream_n_valid[%0d]: got %b want %b", i, n_out_valid, ev_tab[i]); end
            checks++; if (n_out_data !== ed_tab[i]) begin failures++; $display("FAIL stream_n_data[%0d]: got %h want %h", i, n_out_data, ed_tab[i]); end
        end
        checks++; if (s_drop_cnt !== 16'd0) begin failures++; $display("FAIL stream_s_drop: got %0d want 0", s_drop_cnt); end
    endtask

    task automatic test_backpressure();
        logic         v_tab [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [W-1:0] d_tab [7] = '{16'hA0, 16'hA1, 16'hA2, 16'hA2, 16'hA2, 16'h0, 16'h0};
        logic         r_tab [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic         er_tab[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic         ev_tab[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [W-1:0] ed_tab[7] = '{16'h0, 16'hA0, 16'hA0, 16'hA0, 16'hA1, 16'hA2, 16'h0};
        test_reset();
        for (int i = 0; i < 7; i++) begin
            drive(v_tab[i], d_tab[i], r_tab[i], 1'b0, 1'b0);
            $display("backpressure[%0d]: in_ready=%b valid=%b data=%h", i, s_in_ready, s_out_valid, s_out_data);
            checks++; if (s_in_ready !== er_tab[i]) begin failures++; $display("FAIL bp_ready[%0d]: got %b want %b", i, s_in_ready, er_tab[i]); end
            checks++; if (s_out_valid !== ev_tab[i]) begin failures++; $display("FAIL bp_valid[%0d]: got %b want %b", i, s_out_valid, ev_tab[i]); end
            checks++; if (s_out_data !== ed_tab[i]) begin failures++; $display("FAIL bp_data[%0d]: got %h want %h", i, s_out_data, ed_tab[i]); end
        end
    endtask

    task automatic test_flush();
        logic         v_tab [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [W-1:0] d_tab [5] = '{16'h31, 16'h32, 16'h55, 16'h0, 16'h0};
        logic         r_tab [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic         f_tab [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic         er_tab[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic         ev_tab[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [W-1:0] ed_tab[5] = '{16'h0, 16'h31, 16'h31, 16'h0, 16'h0};
        logic [15:0]  es_tab[5] = '{16'd0, 16'd0, 16'd0, 16'd2, 16'd2};
        logic [15:0]  en_tab[5] = '{16'd0, 16'd0, 16'd0, 16'd1, 16'd1};
        test_reset();
        for (int i = 0; i < 5; i++) begin
            drive(v_tab[i], d_tab[i], r_tab[i], 1'b0, f_tab[i]);
            $display("flush[%0d]: s_valid=%b s_data=%h s_drop=%0d n_drop=%0d", i, s_out_valid, s_out_data, s_drop_cnt, n_drop_cnt);
            checks++; if (s_in_ready !== er_tab[i]) begin failures++; $display("FAIL flush_ready[%0d]: got %b want %b", i, s_in_ready, er_tab[i]); end
            checks++; if (s_out_valid !== ev_tab[i]) begin failures++; $display("FAIL flush_valid[%0d]: got %b want %b", i, s_out_valid, ev_tab[i]); end
            checks++; if (s_out_data !== ed_tab[i]) begin failures++; $display("FAIL flush_data[%0d]: got %h want %h", i, s_out_data, ed_tab[i]); end
            checks++; if (s_drop_cnt !== es_tab[i]) begin failures++; $display("FAIL flush_s_drop[%0d]: got %0d want %0d", i, s_drop_cnt, es_tab[i]); end
            checks++; if (n_drop_cnt !== en_tab[i]) begin failures++; $display("FAIL flush_n_drop[%0d]: got %0d want %0d", i, n_drop_cnt, en_tab[i]); end
            checks++; if (n_out_valid !== ev_tab[i]) begin failures++; $display("FAIL flush_n_valid[%0d]: got %b want %b", i, n_out_valid, ev_tab[i]); end
        end
    endtask

    task automatic test_hold_flush();
        logic         v_tab [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [W-1:0] d_tab [5] = '{16'h77, 16'h99, 16'h0, 16'h0, 16'h0};
        logic         r_tab [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic         h_tab [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic         er_tab[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic         ev_tab[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [W-1:0] ed_tab[5] = '{16'h0, 16'h77, 16'h77, 16'h77, 16'h0};
        test_reset();
        for (int i = 0; i < 5; i++) begin
            drive(v_tab[i], d_tab[i], r_tab[i], h_tab[i], h_tab[i]);
            $display("hold_flush[%0d]: in_ready=%b valid=%b data=%h drop=%0d", i, s_in_ready, s_out_valid, s_out_data, s_drop_cnt);
            checks++; if (s_in_ready !== er_tab[i]) begin failures++; $display("FAIL hold_ready[%0d]: got %b want %b", i, s_in_ready, er_tab[i]); end
            checks++; if (s_out_valid !== ev_tab[i]) begin failures++; $display("FAIL hold_valid[%0d]: got %b want %b", i, s_out_valid, ev_tab[i]); end
            checks++; if (s_out_data !== ed_tab[i]) begin failures++; $display("FAIL hold_data[%0d]: got %h want %h", i, s_out_data, ed_tab[i]); end
            checks++; if (s_drop_cnt !== 16'd0) begin failures++; $display("FAIL hold_drop[%0d]: got %0d want 0", i, s_drop_cnt); end
            checks++; if (n_in_ready !== er_tab[i] && i == 1) begin failures++; $display("FAIL hold_n_ready[%0d]: got %b want %b", i, n_in_ready, er_tab[i]); end
        end
    endtask

    task automatic test_saturation();
        logic [1:0] e_tab[4] = '{2'd1, 2'd2, 2'd3, 2'd3};
        test_reset();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, W'(k + 1), 1'b0, 1'b0, 1'b0);
            drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
            checks++; if (t_out_valid !== 1'b1) begin failures++; $display("FAIL sat_loaded[%0d]: got %b want 1", k, t_out_valid); end
            drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
            $display("saturation[%0d]: drop=%0d valid=%b", k, t_drop_cnt, t_out_valid);
            checks++; if (t_drop_cnt !== e_tab[k]) begin failures++; $display("FAIL sat_drop[%0d]: got %0d want %0d", k, t_drop_cnt, e_tab[k]); end
            checks++; if (t_out_valid !== 1'b0) begin failures++; $display("FAIL sat_bubble[%0d]: got %b want 0", k, t_out_valid); end
        end
    endtask

    task automatic test_back_to_back();
        logic         exp_v;
        logic [W-1:0] exp_d;
        test_reset();
        for (int i = 0; i < 10; i++) begin
            drive(i < 8, (i < 8) ? W'(i + 1) : '0, 1'b1, 1'b0, 1'b0);
            exp_v = (i >= 1) && (i <= 8);
            exp_d = exp_v ? W'(i) : '0;
            $display("back_to_back[%0d]: n_ready=%b n_valid=%b n_data=%h", i, n_in_ready, n_out_valid, n_out_data);
            checks++; if (n_in_ready !== 1'b1) begin failures++; $display("FAIL b2b_n_ready[%0d]: got %b want 1", i, n_in_ready); end
            checks++; if (n_out_valid !== exp_v) begin failures++; $display("FAIL b2b_n_valid[%0d]: got %b want %b", i, n_out_valid, exp_v); end
            checks++; if (n_out_data !== exp_d) begin failures++; $display("FAIL b2b_n_data[%0d]: got %h want %h", i, n_out_data, exp_d); end
            checks++; if (s_out_data !== exp_d) begin failures++; $display("FAIL b2b_s_data[%0d]: got %h want %h", i, s_out_data, exp_d); end
        end
    endtask

    initial begin
        rst = 1'b0; hold = 1'b0; flush = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_hold_flush();
        test_saturation();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
